// File: rtl/ocr_reg_wr_arbiter_if.sv
// Write-request bundle between OCR feature-extraction stages and the result-register arbiter.
// Requester i owns req[i], req_addr[i*AW +: AW] and req_data[i*32 +: 32].
interface ocr_reg_wr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    ack;

    modport master (
        output req,
        output req_addr,
        output req_data,
        input  ack
    );

    modport slave (
        input  req,
        input  req_addr,
        input  req_data,
        output ack
    );
endinterface

// File: rtl/ocr_reg_wr_arbiter.sv
// Round-robin write arbiter that shares one bank of NREG 32-bit result registers among NREQ
// requesters, and sequences a multi-cycle bank clear on command.
module ocr_reg_wr_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NREG    = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned CLR_CYC = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    ocr_reg_wr_arbiter_if.slave rq,
    input  logic                clr_req,
    output logic                clr_done,
    output logic [31:0]         reg_d,
    output logic [NREG-1:0]     reg_ce,
    output logic                reg_clr,
    output logic                wr_err,
    output logic                busy
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [31:0]     reg_d_q, reg_d_d;
    logic [NREG-1:0] reg_ce_q, reg_ce_d;
    logic            wr_err_q, wr_err_d;

    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [AW-1:0]   grant_addr;
    logic [31:0]     grant_data;
    logic            addr_ok;
    logic            accept;
    logic [NREQ-1:0] ack;
    logic [NREG-1:0] ce_sel;

    // Requester index base+off, wrapped modulo NREQ (NREQ need not be a power of two).
    function automatic logic [PW-1:0] wrap_add(logic [PW-1:0] base, int unsigned off);
        int unsigned s;
        s = (32'(base) + off) % NREQ;
        return PW'(s);
    endfunction

    // First requester at or after ptr in rotating order wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_vld && rq.req[wrap_add(ptr_q, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(ptr_q, k);
            end
        end
    end

    assign grant_addr = rq.req_addr[32'(grant_idx) * AW +: AW];
    assign grant_data = rq.req_data[32'(grant_idx) * 32 +: 32];
    assign addr_ok    = 32'(grant_addr) < NREG;

    // Clear request wins over any pending write in the same IDLE cycle.
    assign accept = RST_N && (state_q == StIdle) && !clr_req && grant_vld;

    always_comb begin
        ack = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = accept && (32'(grant_idx) == i);
        end
    end

    always_comb begin
        ce_sel = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            ce_sel[r] = addr_ok && (32'(grant_addr) == r);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        reg_d_d  = reg_d_q;
        reg_ce_d = '0;
        wr_err_d = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d = StClear;
                    cnt_d   = CW'(CLR_CYC - 1);
                end else if (grant_vld) begin
                    reg_d_d  = grant_data;
                    reg_ce_d = ce_sel;
                    wr_err_d = !addr_ok;
                    ptr_d    = wrap_add(grant_idx, 1);
                end
            end
            StClear: begin
                if (cnt_q == '0) begin
                    clr_done = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= '0;
            reg_d_q  <= '0;
            reg_ce_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            reg_d_q  <= reg_d_d;
            reg_ce_q <= reg_ce_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign rq.ack  = ack;
    assign reg_d   = reg_d_q;
    assign reg_ce  = reg_ce_q;
    assign wr_err  = wr_err_q;
    assign reg_clr = (state_q == StClear);
    assign busy    = (state_q == StClear);

    // Bank must never see a load and a clear in the same cycle.
    ce_clr_excl_a: assert property (@(posedge CLK) disable iff (!RST_N) !((|reg_ce) && reg_clr));
    ack_onehot_a:  assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(ack));
    err_no_ce_a:   assert property (@(posedge CLK) disable iff (!RST_N) !(wr_err && (|reg_ce)));
endmodule

// File: doc/ocr_reg_wr_arbiter.md
Name: ocr_reg_wr_arbiter

Overview:
- Round-robin write arbiter that shares one bank of NREG 32-bit clock-enabled registers (async active-high clear) among NREQ requesters in the OCR datapath.
- Accepts write requests, selects one per cycle, and drives the bank's shared D bus and its one-hot CE lines.
- Sequences a multi-cycle bank clear on command.
- Feature-extraction stages use it to post results into the shared result-register bank without contention.

Parameters:
NREQ, 4, number of requesters (2..8)
NREG, 8, number of registers in the bank
AW, 3, register address width; NREG <= 2**AW
CLR_CYC, 2, cycles reg_clr is held high during a clear (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
req  in  NREQ  per-requester write request, held until accepted
req_addr  in  NREQ*AW  register index of requester i at bits [i*AW +: AW]
req_data  in  NREQ*32  write data of requester i at bits [i*32 +: 32]
ack  out  NREQ  combinational accept; a transfer occurs at a rising edge where req[i] & ack[i]
clr_req  in  1  bank clear request (level, sampled in IDLE)
clr_done  out  1  one-cycle pulse on the last clear cycle
reg_d  out  32  registered data to the bank D inputs
reg_ce  out  NREG  registered one-hot CE to the bank
reg_clr  out  1  registered clear to the bank RST inputs
wr_err  out  1  registered pulse: the accepted write had addr >= NREG
busy  out  1  high in CLEAR state

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, ptr=0, reg_d=0, reg_ce=0, reg_clr=0, wr_err=0, clr_done=0. Combinational ack=0 while RST_N is low.
- FSM states:
  - IDLE. If clr_req=1 at an edge, go to CLEAR (clear has priority; ack=0 in that cycle; no write is accepted).
  - CLEAR. reg_clr=1, busy=1, ack=0, reg_ce=0. Down-counter loaded with CLR_CYC-1. When the counter reaches 0, clr_done=1 for that cycle and the next state is IDLE. reg_clr drops the cycle after.
- Arbitration, IDLE with clr_req=0:
  - Winner g = first i with req[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - ack is one-hot {g}; ack=0 if no req.
- Transfer at an edge where ack[g]=1:
  - reg_d <= req_data[g].
  - reg_ce <= one-hot(req_addr[g]) if addr < NREG, else reg_ce <= 0 and wr_err <= 1.
  - ptr <= (g+1) mod NREQ.
- No transfer: reg_ce <= 0, wr_err <= 0, reg_d holds its value. ptr is unchanged.
- Latency: the bank register captures the data at edge N+2, where edge N+1 is the transfer edge. One write per cycle sustained.
- Back-to-back requests from the same requester are allowed. Its req stays high with new data after its ack. Fairness comes from the ptr rotation.
- CE and clear are never both high in the same cycle.
- ptr is preserved across CLEAR.
- RST_N asserted mid-CLEAR aborts the sequence immediately and forces all outputs to reset values. No clr_done is produced.
- req/addr/data may change freely when ack is low. A requester must hold req, addr and data stable while waiting.

Test Plan:
- Reset: RST_N=0 mid-cycle with req=4'b1111 -> ack=0, reg_ce=0, reg_clr=0 immediately. Release -> first ack=4'b0001.
- Single write: req[2]=1, addr=5, data=32'hDEADBEEF -> ack=4'b0100 in the same cycle. Next cycle reg_ce=8'b0010_0000, reg_d=32'hDEADBEEF for exactly 1 cycle.
- Round robin: req=4'b1111 held 8 cycles, distinct data -> grant order 0,1,2,3,0,1,2,3. Each reg_ce one-hot matches that requester's addr.
- Fairness skip: ptr=1, req=4'b1001 -> grants 3 then 0, then 3 again.
- Clear priority: clr_req=1 with req=4'b0010 pending, CLR_CYC=2 -> ack=0 that cycle. reg_clr=1 for 2 cycles, busy=1, clr_done on the 2nd. Next IDLE cycle ack=4'b0010.
- Bad address, NREG=6: req[0], addr=7 -> ack[0]=1. Next cycle reg_ce=0, wr_err=1, ptr advances to 1.
